// File: rtl/freq_hop_pkg.sv
// freq_hop_pkg
//   Shared types for the frequency-hop scheduler.
//   state_t     : scheduler FSM states.
//   hop_entry_t : one table entry, a DDS phase increment plus its dwell count.
//                 The dwell field is sized for the widest supported dwell
//                 (DWELL_MAX_W); the scheduler zero-extends its DWELL_W-bit
//                 configuration value into it, so DWELL_W must not exceed it.
package freq_hop_pkg;

  localparam int DWELL_MAX_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    DWELL
  } state_t;

  typedef struct packed {
    logic [15:0]            phase_inc;
    logic [DWELL_MAX_W-1:0] dwell;
  } hop_entry_t;

endpackage

// File: rtl/freq_hop_scheduler_hop_table.sv
// hop_table
//   DEPTH x hop_entry_t register array, one synchronous write port and one
//   asynchronous read port.
//   clock   : write clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : entry to write
//   raddr_i : read address
//   rdata_o : entry at raddr_i (combinational)
module hop_table
  import freq_hop_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  hop_entry_t    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output hop_entry_t    rdata_o
);

  hop_entry_t mem_q [DEPTH];

  // NOTE: the array has no reset on purpose - a reset must leave the
  // programmed hop table intact, and an unreset array maps onto plain
  // register/RAM cells without a reset tree.
  always_ff @(posedge clock) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/freq_hop_scheduler.sv
// freq_hop_scheduler
//   Steps the frequency shifter's DDS phase increment through a programmed
//   hop table. Each hop spends SETTLE_CYCLES with out_valid low while the
//   shifter pipeline flushes, then max(dwell,1) cycles with out_valid high.
//   Ports:
//     clock, reset          : clock, asynchronous active-high reset
//     cfg_we/addr/phase_inc/dwell : table write port, accepted only when idle
//     cfg_last, cfg_loop    : last active entry and wrap mode, latched at start
//     start, stop           : sequence start / abort pulses (stop wins)
//     dds_phase_inc         : phase increment to the shifter
//     hop_index             : entry currently applied
//     hop_strobe            : pulse on each dds_phase_inc update
//     out_valid             : shifter output settled on the current hop
//     running               : sequencer not idle
//     done                  : pulse on natural end of a non-looping sequence
//     cfg_err               : pulse when a table write was rejected
//   All outputs are registered.
module freq_hop_scheduler
  import freq_hop_pkg::*;
#(
  parameter int TABLE_DEPTH   = 16,
  parameter int SETTLE_CYCLES = 12,
  parameter int DWELL_W       = 24,
  parameter int AW            = $clog2(TABLE_DEPTH)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [AW-1:0]      cfg_addr,
  input  logic [15:0]        cfg_phase_inc,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [AW-1:0]      cfg_last,
  input  logic               cfg_loop,
  input  logic               start,
  input  logic               stop,
  output logic [15:0]        dds_phase_inc,
  output logic [AW-1:0]      hop_index,
  output logic               hop_strobe,
  output logic               out_valid,
  output logic               running,
  output logic               done,
  output logic               cfg_err
);

  localparam logic [DWELL_MAX_W-1:0] SETTLE_LOAD = DWELL_MAX_W'(SETTLE_CYCLES - 1);

  state_t                 state_q, state_d;
  logic [DWELL_MAX_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]          idx_q, idx_d;
  logic [15:0]            inc_q, inc_d;
  logic [AW-1:0]          last_q, last_d;
  logic                   loop_q, loop_d;
  logic                   strobe_q, strobe_d;
  logic                   valid_q, valid_d;
  logic                   running_q, running_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic [AW-1:0] next_idx;
  logic [AW-1:0] rd_addr;
  hop_entry_t    wr_entry;
  hop_entry_t    rd_entry;

  // The single read port serves two purposes: in SETTLE it fetches the dwell
  // of the current hop, in IDLE/DWELL it fetches the entry about to be applied.
  assign next_idx = (idx_q == last_q) ? '0 : AW'(idx_q + 1'b1);
  assign rd_addr  = (state_q == IDLE)   ? '0    :
                    (state_q == SETTLE) ? idx_q : next_idx;

  assign wr_entry.phase_inc = cfg_phase_inc;
  assign wr_entry.dwell     = DWELL_MAX_W'(cfg_dwell);

  hop_table #(
    .DEPTH (TABLE_DEPTH),
    .AW    (AW)
  ) u_table (
    .clock   (clock),
    .we_i    (cfg_we && (state_q == IDLE)),
    .waddr_i (cfg_addr),
    .wdata_i (wr_entry),
    .raddr_i (rd_addr),
    .rdata_o (rd_entry)
  );

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    inc_d    = inc_q;
    last_d   = last_q;
    loop_d   = loop_q;
    strobe_d = 1'b0;
    done_d   = 1'b0;
    err_d    = cfg_we && (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          last_d   = cfg_last;
          loop_d   = cfg_loop;
          idx_d    = '0;
          inc_d    = rd_entry.phase_inc;
          strobe_d = 1'b1;
          cnt_d    = SETTLE_LOAD;
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        if (stop) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          // A zero dwell is stretched to one valid cycle.
          cnt_d   = (rd_entry.dwell == '0) ? '0 : rd_entry.dwell - 1'b1;
          state_d = DWELL;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DWELL: begin
        if (stop) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          if ((idx_q != last_q) || loop_q) begin
            idx_d    = next_idx;
            inc_d    = rd_entry.phase_inc;
            strobe_d = 1'b1;
            cnt_d    = SETTLE_LOAD;
            state_d  = SETTLE;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    valid_d   = (state_d == DWELL);
    running_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of the others.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      inc_q     <= '0;
      last_q    <= '0;
      loop_q    <= 1'b0;
      strobe_q  <= 1'b0;
      valid_q   <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      inc_q     <= inc_d;
      last_q    <= last_d;
      loop_q    <= loop_d;
      strobe_q  <= strobe_d;
      valid_q   <= valid_d;
      running_q <= running_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign dds_phase_inc = inc_q;
  assign hop_index     = idx_q;
  assign hop_strobe    = strobe_q;
  assign out_valid     = valid_q;
  assign running       = running_q;
  assign done          = done_q;
  assign cfg_err       = err_q;

endmodule

// File: tb/tb_freq_hop_scheduler.sv
// tb_freq_hop_scheduler
//   Scenario tasks drive the scheduler and compare every output, cycle by
//   cycle, against a schedule computed from the hop table with plain
//   arithmetic (hop k starts at 1 + sum of earlier hop periods).
module tb_freq_hop_scheduler;

  localparam int TABLE_DEPTH   = 16;
  localparam int SETTLE_CYCLES = 12;
  localparam int DWELL_W       = 24;
  localparam int AW            = 4;
  localparam int MAXC          = 1024;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               cfg_we = 1'b0;
  logic [AW-1:0]      cfg_addr = '0;
  logic [15:0]        cfg_phase_inc = '0;
  logic [DWELL_W-1:0] cfg_dwell = '0;
  logic [AW-1:0]      cfg_last = '0;
  logic               cfg_loop = 1'b0;
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic [15:0]        dds_phase_inc;
  logic [AW-1:0]      hop_index;
  logic               hop_strobe;
  logic               out_valid;
  logic               running;
  logic               done;
  logic               cfg_err;

  int checks = 0;
  int errors = 0;

  // Reference copy of the table contents.
  logic [15:0] m_inc   [TABLE_DEPTH];
  int          m_dwell [TABLE_DEPTH];

  // Expected outputs, indexed by cycle offset from the start sample (1 = first
  // cycle after start was sampled).
  bit            e_strobe [0:MAXC];
  bit            e_valid  [0:MAXC];
  bit            e_run    [0:MAXC];
  bit            e_done   [0:MAXC];
  logic [15:0]   e_inc    [0:MAXC];
  logic [AW-1:0] e_idx    [0:MAXC];

  freq_hop_scheduler #(
    .TABLE_DEPTH   (TABLE_DEPTH),
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .DWELL_W       (DWELL_W)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .cfg_we        (cfg_we),
    .cfg_addr      (cfg_addr),
    .cfg_phase_inc (cfg_phase_inc),
    .cfg_dwell     (cfg_dwell),
    .cfg_last      (cfg_last),
    .cfg_loop      (cfg_loop),
    .start         (start),
    .stop          (stop),
    .dds_phase_inc (dds_phase_inc),
    .hop_index     (hop_index),
    .hop_strobe    (hop_strobe),
    .out_valid     (out_valid),
    .running       (running),
    .done          (done),
    .cfg_err       (cfg_err)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic build_model(input int last, input bit loop, input int ncyc, input int stop_off);
    int off = 1;
    int k = 0;
    int d;
    bit ended = 0;
    for (int i = 0; i <= ncyc; i++) begin
      e_strobe[i] = 0; e_valid[i] = 0; e_run[i] = 0; e_done[i] = 0;
      e_inc[i] = '0; e_idx[i] = '0;
    end
    while (off <= ncyc && !ended) begin
      d = (m_dwell[k] == 0) ? 1 : m_dwell[k];
      for (int c = 0; c < SETTLE_CYCLES + d; c++) begin
        if (off + c <= ncyc) begin
          e_run[off+c]    = 1;
          e_inc[off+c]    = m_inc[k];
          e_idx[off+c]    = AW'(k);
          e_strobe[off+c] = (c == 0);
          e_valid[off+c]  = (c >= SETTLE_CYCLES);
        end
      end
      off += SETTLE_CYCLES + d;
      if (k == last && !loop) begin
        ended = 1;
        if (off <= ncyc) e_done[off] = 1;
        for (int i = off; i <= ncyc; i++) begin
          e_inc[i] = m_inc[k];
          e_idx[i] = AW'(k);
        end
      end else begin
        k = (k == last) ? 0 : k + 1;
      end
    end
    if (stop_off > 0) begin
      for (int i = stop_off + 1; i <= ncyc; i++) begin
        e_strobe[i] = 0; e_valid[i] = 0; e_run[i] = 0; e_done[i] = 0;
        e_inc[i] = e_inc[stop_off];
        e_idx[i] = e_idx[stop_off];
      end
    end
  endtask

  // Must be called while idle, at #1 after an edge.
  task automatic write_entry(input int addr, input logic [15:0] inc, input int dwell);
    cfg_we = 1'b1;
    cfg_addr = AW'(addr);
    cfg_phase_inc = inc;
    cfg_dwell = DWELL_W'(dwell);
    step();
    cfg_we = 1'b0;
    m_inc[addr] = inc;
    m_dwell[addr] = dwell;
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL write_idle addr=%0d cfg_err got=%0b exp=0", addr, cfg_err);
    end
  endtask

  // Starts a sequence and compares all outputs for ncyc cycles; stop is
  // pulsed during offset stop_off (0 = never).
  task automatic run_and_check(input string name, input int last, input bit loop,
                               input int ncyc, input int stop_off);
    build_model(last, loop, ncyc, stop_off);
    cfg_last = AW'(last);
    cfg_loop = loop;
    start = 1'b1;
    for (int off = 1; off <= ncyc; off++) begin
      step();
      start = 1'b0;
      stop = 1'b0;
      checks++;
      if (hop_strobe !== e_strobe[off]) begin
        errors++;
        $display("FAIL %s off=%0d hop_strobe got=%0b exp=%0b", name, off, hop_strobe, e_strobe[off]);
      end
      checks++;
      if (out_valid !== e_valid[off]) begin
        errors++;
        $display("FAIL %s off=%0d out_valid got=%0b exp=%0b", name, off, out_valid, e_valid[off]);
      end
      checks++;
      if (running !== e_run[off]) begin
        errors++;
        $display("FAIL %s off=%0d running got=%0b exp=%0b", name, off, running, e_run[off]);
      end
      checks++;
      if (done !== e_done[off]) begin
        errors++;
        $display("FAIL %s off=%0d done got=%0b exp=%0b", name, off, done, e_done[off]);
      end
      checks++;
      if (dds_phase_inc !== e_inc[off]) begin
        errors++;
        $display("FAIL %s off=%0d dds_phase_inc got=%h exp=%h", name, off, dds_phase_inc, e_inc[off]);
      end
      checks++;
      if (hop_index !== e_idx[off]) begin
        errors++;
        $display("FAIL %s off=%0d hop_index got=%0d exp=%0d", name, off, hop_index, e_idx[off]);
      end
      checks++;
      if (cfg_err !== 1'b0) begin
        errors++;
        $display("FAIL %s off=%0d cfg_err got=%0b exp=0", name, off, cfg_err);
      end
      if (off == stop_off) stop = 1'b1;
    end
    stop = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    checks++;
    if ({dds_phase_inc, hop_index, hop_strobe, out_valid, running, done, cfg_err} !== '0) begin
      errors++;
      $display("FAIL reset_state outputs got=%h/%0d/%0b%0b%0b%0b%0b exp=all zero",
               dds_phase_inc, hop_index, hop_strobe, out_valid, running, done, cfg_err);
    end
    reset = 1'b0;
    step();
    checks++;
    if (running !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release running=%0b out_valid=%0b exp=0,0", running, out_valid);
    end
  endtask

  task automatic test_two_hops();
    write_entry(0, 16'h0400, 100);
    write_entry(1, 16'h0800, 50);
    run_and_check("two_hops", 1, 1'b0, 180, 0);
  endtask

  task automatic test_loop_single();
    write_entry(0, 16'h1234, 0);
    run_and_check("loop_single", 0, 1'b1, 60, 45);
    step();
  endtask

  task automatic test_stop_settle();
    write_entry(0, 16'h0400, 100);
    run_and_check("stop_settle", 1, 1'b0, 30, 5);
  endtask

  task automatic test_write_while_running();
    cfg_last = AW'(1);
    cfg_loop = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    cfg_we = 1'b1;
    cfg_addr = AW'(1);
    cfg_phase_inc = 16'hBEEF;
    cfg_dwell = DWELL_W'(3);
    step();
    cfg_we = 1'b0;
    checks++;
    if (cfg_err !== 1'b1) begin
      errors++;
      $display("FAIL write_busy cfg_err got=%0b exp=1", cfg_err);
    end
    step();
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL write_busy_pulse cfg_err got=%0b exp=0", cfg_err);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    checks++;
    if (running !== 1'b0) begin
      errors++;
      $display("FAIL write_busy_stop running got=%0b exp=0", running);
    end
    // Model is untouched by the rejected write: the replay must use it.
    run_and_check("table_unchanged", 1, 1'b0, 180, 0);
  endtask

  task automatic test_start_stop();
    cfg_last = '0;
    cfg_loop = 1'b1;
    start = 1'b1;
    stop = 1'b1;
    step();
    start = 1'b0;
    stop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (running !== 1'b0 || hop_strobe !== 1'b0) begin
        errors++;
        $display("FAIL start_stop cyc=%0d running=%0b hop_strobe=%0b exp=0,0", i, running, hop_strobe);
      end
      step();
    end
  endtask

  task automatic test_reset_mid_dwell();
    cfg_last = AW'(1);
    cfg_loop = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (19) step();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_dwell out_valid got=%0b exp=1", out_valid);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({dds_phase_inc, hop_index, hop_strobe, out_valid, running, done, cfg_err} !== '0) begin
      errors++;
      $display("FAIL async_reset outputs got=%h/%0d/%0b%0b%0b%0b%0b exp=all zero",
               dds_phase_inc, hop_index, hop_strobe, out_valid, running, done, cfg_err);
    end
    step();
    reset = 1'b0;
    step();
    run_and_check("replay_after_reset", 1, 1'b0, 180, 0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      int last = $urandom_range(0, 3);
      bit loop = 1'($urandom_range(0, 1));
      int sum = 0;
      int ncyc;
      int stop_off;
      for (int k = 0; k <= last; k++) begin
        int dw = $urandom_range(0, 15);
        write_entry(k, 16'($urandom), dw);
        sum += SETTLE_CYCLES + ((dw == 0) ? 1 : dw);
      end
      if (loop) begin
        ncyc = 2 * sum + 3;
        stop_off = $urandom_range(sum, 2 * sum);
      end else begin
        ncyc = sum + 4;
        stop_off = ($urandom_range(0, 1) == 1) ? $urandom_range(1, sum) : 0;
      end
      run_and_check($sformatf("random%0d", it), last, loop, ncyc, stop_off);
    end
  endtask

  initial begin
    test_reset();
    test_two_hops();
    test_loop_single();
    test_stop_settle();
    test_write_while_running();
    test_start_stop();
    test_reset_mid_dwell();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
